bitwise_logic_pipe: RTL

//   Parametrised, pipelined successor to the fixed 32-bit per-bit AND array.
//   Per-bit logic unit: AND/OR/XOR/NOR/ANDN/PASS on WIDTH-bit operands.

---
 rtl/bitwise_logic_if.sv | 30 +++
 rtl/bitwise_logic_pipe.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_if.sv
// Handshake bundle for the pipelined per-bit logic unit: an input beat channel
// and a result channel, both valid/ready.
interface bitwise_logic_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             in_acc;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_zero;
   logic             out_err;

   // Producer/consumer side of the unit.
   modport master (
      output in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
      input  in_ready, out_valid, out_result, out_zero, out_err
   );

   // The logic unit itself.
   modport slave (
      input  in_valid, in_a, in_b, in_op, in_acc, in_last, out_ready,
      output in_ready, out_valid, out_result, out_zero, out_err
   );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Two-stage per-bit logic unit (AND/OR/XOR/NOR/ANDN/PASS) with valid/ready on
// both sides and a burst-reduction mode that folds a beat sequence into one result.
module bitwise_logic_pipe #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   bitwise_logic_if.slave bus
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_ANDN = 3'b100;
   localparam logic [2:0] OP_PASS = 3'b101;

   function automatic logic [WIDTH-1:0] logic_op(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] x,
      input logic [WIDTH-1:0] y
   );
      logic [WIDTH-1:0] r;
      case (op)
         OP_AND:  r = x & y;
         OP_OR:   r = x | y;
         OP_XOR:  r = x ^ y;
         OP_NOR:  r = ~(x | y);
         OP_ANDN: r = x & ~y;
         OP_PASS: r = x;
         default: r = {WIDTH{1'b0}};
      endcase
      return r;
   endfunction

   function automatic logic illegal_op(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   // Stage-1 holding registers
   logic             s1_valid_r;
   logic [WIDTH-1:0] s1_a_r;
   logic [WIDTH-1:0] s1_b_r;
   logic [2:0]       s1_op_r;
   logic             s1_acc_r;
   logic             s1_last_r;

   // Burst state and registered outputs
   logic [WIDTH-1:0] acc_r;
   logic             burst_r;
   logic             sticky_err_r;
   logic             out_valid_r;
   logic [WIDTH-1:0] out_result_r;
   logic             out_zero_r;
   logic             out_err_r;

   logic             s2_adv_s;
   logic             s1_adv_s;
   logic             ill_s;
   logic [WIDTH-1:0] norm_val_s;
   logic [WIDTH-1:0] burst_val_s;
   logic             burst_err_s;

   // Handshake advance terms and stage-2 datapath values.
   always_comb begin
      s2_adv_s    = ~out_valid_r | bus.out_ready;
      s1_adv_s    = ~s1_valid_r | s2_adv_s;
      ill_s       = illegal_op(s1_op_r);
      norm_val_s  = logic_op(s1_op_r, s1_a_r, s1_b_r);
      burst_err_s = sticky_err_r | ill_s;
      // The first beat of a burst seeds the accumulator with its operand.
      if (burst_r) begin
         burst_val_s = logic_op(s1_op_r, acc_r, s1_a_r);
      end else begin
         burst_val_s = s1_a_r;
      end
   end

   // Stage 1: capture an accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_r <= 1'b0;
         s1_a_r     <= {WIDTH{1'b0}};
         s1_b_r     <= {WIDTH{1'b0}};
         s1_op_r    <= 3'b000;
         s1_acc_r   <= 1'b0;
         s1_last_r  <= 1'b0;
      end else if (s1_adv_s) begin
         s1_valid_r <= bus.in_valid;
         s1_a_r     <= bus.in_a;
         s1_b_r     <= bus.in_b;
         s1_op_r    <= bus.in_op;
         s1_acc_r   <= bus.in_acc;
         s1_last_r  <= bus.in_last;
      end
   end

   // Stage 2: compute, update burst state, register the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r  <= 1'b0;
         out_result_r <= {WIDTH{1'b0}};
         out_zero_r   <= 1'b0;
         out_err_r    <= 1'b0;
         acc_r        <= {WIDTH{1'b0}};
         burst_r      <= 1'b0;
         sticky_err_r <= 1'b0;
      end else if (s2_adv_s) begin
         if (s1_valid_r && !s1_acc_r) begin
            out_valid_r  <= 1'b1;
            out_result_r <= norm_val_s;
            out_zero_r   <= (norm_val_s == {WIDTH{1'b0}});
            out_err_r    <= ill_s;
         end else if (s1_valid_r && s1_last_r) begin
            out_valid_r  <= 1'b1;
            out_result_r <= burst_val_s;
            out_zero_r   <= (burst_val_s == {WIDTH{1'b0}});
            out_err_r    <= burst_err_s;
            acc_r        <= {WIDTH{1'b0}};
            burst_r      <= 1'b0;
            sticky_err_r <= 1'b0;
         end else if (s1_valid_r) begin
            // Non-last burst beat is absorbed; previous output already left.
            out_valid_r  <= 1'b0;
            acc_r        <= burst_val_s;
            burst_r      <= 1'b1;
            sticky_err_r <= burst_err_s;
         end else begin
            out_valid_r  <= 1'b0;
         end
      end
   end

   assign bus.in_ready   = rst_n & s1_adv_s;
   assign bus.out_valid  = out_valid_r;
   assign bus.out_result = out_result_r;
   assign bus.out_zero   = out_zero_r;
   assign bus.out_err    = out_err_r;

endmodule
